// File: rtl/ysyx_24080006_mdu.sv
// ysyx_24080006_mdu: iterative RV32M multiply/divide unit sharing the core ALU subtractor
package ysyx_24080006_mdu_pkg;
  typedef enum logic [1:0] {MDU_MULL, MDU_MULH, MDU_DIV, MDU_REM} mdu_op_t;
  typedef struct packed {
    logic    mdu_enable;
    logic    signed_a;
    logic    signed_b;
    mdu_op_t mdu_op;
  } mdu_set_t;
  typedef struct packed {
    logic [32:0] a;
    logic [32:0] b;
  } mdu2alu_t;
  typedef struct packed {
    logic [33:0] res_34;
    logic [31:0] res_32;
    logic        not_zero;
  } alu2mdu_t;
endpackage

module ysyx_24080006_mdu
  import ysyx_24080006_mdu_pkg::*;
(
  input  logic        clock,
  input  logic        reset,
  input  logic        flush,
  input  logic        in_valid,
  output logic        in_ready,
  input  mdu_set_t    mdu_set,
  input  logic [31:0] src1,
  input  logic [31:0] src2,
  output mdu2alu_t    alu_req,
  input  alu2mdu_t    alu_rsp,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] result
);
  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;
  state_t      state;
  mdu_op_t     op;
  logic [5:0]  cnt;
  logic [32:0] hi, lo, mcand, neg_mcand;
  logic        qneg, rneg;
  logic        s1, sb, s2d, in_mul, is_mul;
  logic [32:0] a33, b33;
  logic [31:0] mag1, mag2;
  logic [33:0] res;
  logic        unused_ok;
  assign res       = alu_rsp.res_34;
  assign unused_ok = ^{alu_rsp.res_32, alu_rsp.not_zero};
  assign in_ready  = state == IDLE;
  assign out_valid = state == DONE;
  assign is_mul    = ~op[1];
  // operand extension and divide magnitudes at accept time
  always_comb begin
    in_mul = ~mdu_set.mdu_op[1];
    s1     = mdu_set.signed_a & src1[31];
    sb     = mdu_set.signed_b & src2[31];
    s2d    = mdu_set.signed_a & src2[31];
    a33    = {s1, src1};
    b33    = {sb, src2};
    mag1   = s1 ? -src1 : src1;
    mag2   = s2d ? -src2 : src2;
  end
  // shared ALU operands, driven only while iterating; the last multiply step subtracts the sign weight
  always_comb begin
    alu_req = '0;
    if (state == CALC) begin
      alu_req.a = is_mul ? hi : {hi[31:0], lo[31]};
      alu_req.b = is_mul ? (lo[0] ? (cnt == 6'd32 ? mcand : neg_mcand) : 33'd0) : {1'b0, mcand[31:0]};
    end
  end
  // control FSM and datapath registers
  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= IDLE;
      op        <= MDU_MULL;
      cnt       <= '0;
      hi        <= '0;
      lo        <= '0;
      mcand     <= '0;
      neg_mcand <= '0;
      qneg      <= 1'b0;
      rneg      <= 1'b0;
      result    <= '0;
    end else if (flush) begin
      state <= IDLE;
    end else begin
      case (state)
        IDLE: if (in_valid & mdu_set.mdu_enable) begin
          op   <= mdu_set.mdu_op;
          cnt  <= '0;
          hi   <= '0;
          qneg <= s1 ^ s2d;
          rneg <= s1;
          if (in_mul) begin
            lo        <= b33;
            mcand     <= a33;
            neg_mcand <= ~a33 + 33'd1;
            state     <= CALC;
          end else begin
            lo    <= {1'b0, mag1};
            mcand <= {1'b0, mag2};
            if (src2 == 32'd0) begin
              result <= mdu_set.mdu_op == MDU_DIV ? 32'hFFFF_FFFF : src1;
              state  <= DONE;
            end else begin
              state <= CALC;
            end
          end
        end
        CALC: begin
          cnt <= cnt + 6'd1;
          if (is_mul) begin
            {hi, lo} <= {res, lo[32:1]};
            if (cnt == 6'd32) begin
              result <= op == MDU_MULL ? lo[32:1] : res[31:0];
              state  <= DONE;
            end
          end else begin
            hi <= res[33] ? alu_req.a : res[32:0];
            lo <= {1'b0, lo[30:0], ~res[33]};
            if (cnt == 6'd31) state <= FIX;
          end
        end
        FIX: begin
          result <= op == MDU_DIV ? (qneg ? -lo[31:0] : lo[31:0]) : (rneg ? -hi[31:0] : hi[31:0]);
          state  <= DONE;
        end
        DONE: if (out_ready) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_ysyx_24080006_mdu.sv
// tb_ysyx_24080006_mdu: directed vector bench for the iterative multiply/divide unit
module tb_ysyx_24080006_mdu;
  import ysyx_24080006_mdu_pkg::*;
  logic        clock = 0, reset = 1, flush = 0, in_valid = 0, out_ready = 0;
  logic        in_ready, out_valid;
  mdu_set_t    mdu_set = '0;
  logic [31:0] src1 = 0, src2 = 0, result;
  mdu2alu_t    alu_req;
  alu2mdu_t    alu_rsp;
  int          checks = 0, errors = 0;
  typedef struct {
    mdu_op_t     op;
    logic        sa;
    logic        sb;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    int          lat;
  } vec_t;
  vec_t v[16];
  ysyx_24080006_mdu dut (
    .clock(clock), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .mdu_set(mdu_set), .src1(src1), .src2(src2), .alu_req(alu_req), .alu_rsp(alu_rsp),
    .out_valid(out_valid), .out_ready(out_ready), .result(result)
  );
  always #5 clock = ~clock;
  assign alu_rsp.res_34   = {alu_req.a[32], alu_req.a} - {alu_req.b[32], alu_req.b};
  assign alu_rsp.res_32   = '0;
  assign alu_rsp.not_zero = 1'b0;
  task automatic check(input string name, input logic [66:0] act, input logic [66:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", name, act, exp);
    end
  endtask
  task automatic offer(input mdu_op_t op, input logic sa, input logic sb, input logic [31:0] a, input logic [31:0] b);
    in_valid = 1;
    mdu_set  = '{mdu_enable: 1'b1, signed_a: sa, signed_b: sb, mdu_op: op};
    src1     = a;
    src2     = b;
    @(posedge clock);
    #1 in_valid = 0;
  endtask
  task automatic wait_valid(output int n);
    n = 1;
    while (!out_valid && n < 200) begin
      @(posedge clock);
      #1 n++;
    end
  endtask
  task automatic pop();
    out_ready = 1;
    @(posedge clock);
    #1 out_ready = 0;
  endtask
  task automatic run_op(input string name, input vec_t t);
    int n;
    offer(t.op, t.sa, t.sb, t.a, t.b);
    wait_valid(n);
    check({name, " latency"}, 67'(n), 67'(t.lat));
    check({name, " result"}, 67'(result), 67'(t.exp));
    pop();
  endtask
  initial begin
    int n;
    logic [31:0] held;
    vec_t t;
    v[0]  = '{MDU_MULL, 1, 1, 32'd7,         32'hFFFF_FFFD, 32'hFFFF_FFEB, 34};
    v[1]  = '{MDU_MULH, 1, 1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 34};
    v[2]  = '{MDU_MULH, 0, 0, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 34};
    v[3]  = '{MDU_MULH, 1, 0, 32'hFFFF_FFFF, 32'd2,         32'hFFFF_FFFF, 34};
    v[4]  = '{MDU_MULH, 0, 0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 34};
    v[5]  = '{MDU_MULL, 0, 0, 32'h1234_5678, 32'h10,        32'h2345_6780, 34};
    v[6]  = '{MDU_DIV,  1, 0, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, 34};
    v[7]  = '{MDU_REM,  1, 0, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 34};
    v[8]  = '{MDU_DIV,  0, 0, 32'hFFFF_FFFE, 32'd3,         32'h5555_5554, 34};
    v[9]  = '{MDU_DIV,  1, 0, 32'h0000_0042, 32'd0,         32'hFFFF_FFFF, 1};
    v[10] = '{MDU_REM,  1, 0, 32'h0000_1234, 32'd0,         32'h0000_1234, 1};
    v[11] = '{MDU_DIV,  1, 0, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 34};
    v[12] = '{MDU_REM,  1, 0, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 34};
    v[13] = '{MDU_REM,  0, 0, 32'd100,       32'd7,         32'd2,         34};
    v[14] = '{MDU_DIV,  1, 0, 32'd7,         32'hFFFF_FFFE, 32'hFFFF_FFFD, 34};
    v[15] = '{MDU_REM,  1, 0, 32'd7,         32'hFFFF_FFFE, 32'd1,         34};
    repeat (2) @(posedge clock);
    #1 reset = 0;
    check("reset in_ready", 67'(in_ready), 67'(1));
    check("reset out_valid", 67'(out_valid), 67'(0));
    check("reset result", 67'(result), 67'(0));
    check("reset alu_req", 67'(alu_req), 67'(0));
    for (int i = 0; i < 16; i++) run_op($sformatf("vec%0d", i), v[i]);
    offer(MDU_DIV, 0, 0, 32'd100, 32'd7);
    wait_valid(n);
    check("bp latency", 67'(n), 67'(34));
    held = result;
    check("bp result", 67'(held), 67'(14));
    in_valid = 1;
    mdu_set  = '{mdu_enable: 1'b1, signed_a: 1'b0, signed_b: 1'b0, mdu_op: MDU_MULL};
    src1 = 32'd9;
    src2 = 32'd9;
    for (int i = 0; i < 10; i++) begin
      @(posedge clock);
      #1;
      check("bp hold result", 67'(result), 67'(held));
      check("bp in_ready", 67'(in_ready), 67'(0));
      check("bp out_valid", 67'(out_valid), 67'(1));
    end
    in_valid = 0;
    pop();
    check("bp after pop in_ready", 67'(in_ready), 67'(1));
    check("bp after pop out_valid", 67'(out_valid), 67'(0));
    offer(MDU_MULL, 1, 1, 32'd1234, 32'd5678);
    repeat (10) @(posedge clock);
    #1 flush = 1;
    check("step10 alu busy", 67'(alu_req != '0), 67'(1));
    @(posedge clock);
    #1 flush = 0;
    check("flush in_ready", 67'(in_ready), 67'(1));
    check("flush out_valid", 67'(out_valid), 67'(0));
    check("flush alu_req", 67'(alu_req), 67'(0));
    offer(MDU_DIV, 1, 0, 32'd5000, 32'd3);
    repeat (10) @(posedge clock);
    #1 reset = 1;
    @(posedge clock);
    #1 reset = 0;
    check("reset mid in_ready", 67'(in_ready), 67'(1));
    check("reset mid out_valid", 67'(out_valid), 67'(0));
    check("reset mid alu_req", 67'(alu_req), 67'(0));
    check("reset mid result", 67'(result), 67'(0));
    t = '{MDU_MULL, 0, 0, 32'd3, 32'd5, 32'd15, 34};
    run_op("mull 3x5", t);
    in_valid = 1;
    mdu_set  = '{mdu_enable: 1'b0, signed_a: 1'b1, signed_b: 1'b1, mdu_op: MDU_DIV};
    src1 = 32'd10;
    src2 = 32'd0;
    n = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clock);
      #1;
      if (!in_ready || out_valid || alu_req != '0) n++;
    end
    in_valid = 0;
    check("enable gating", 67'(n), 67'(0));
    check("enable gating out_valid", 67'(out_valid), 67'(0));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/ysyx_24080006_mdu.md
# ysyx_24080006_mdu

Iterative multiply/divide unit for the RV32M extension of the ysyx_24080006 core. It accepts one `mdu_set_t` operation with two 32-bit operands from the execute stage and runs a shift-add multiply or a restoring divide. It borrows the core ALU's adder through the `mdu2alu_t`/`alu2mdu_t` pair, so it has no wide adder of its own. The execute stage stalls on the valid/ready handshakes.

## Interface
- No parameters; `REG_WIDTH` is unused.
- `clock`  in  1  system clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-high.
- `flush`  in  1  aborts any operation in flight.
- `in_valid`  in  1  operation offered.
- `in_ready`  out  1  high exactly when in IDLE.
- `mdu_set`  in  `mdu_set_t`  `mdu_enable`, `signed_a`, `signed_b`, `mdu_op`.
- `src1`, `src2`  in  32 each  rs1 and rs2 values.
- `alu_req`  out  `mdu2alu_t`  33-bit operands `a` and `b` for the shared ALU.
- `alu_rsp`  in  `alu2mdu_t`  ALU returns `res_34 = sext34(a) - sext34(b)`, combinationally, in the same cycle; `res_32` and `not_zero` are ignored.
- `out_valid`  out  1  result available.
- `out_ready`  in  1  consumer takes the result.
- `result`  out  32  rd write value.

## Operation
- **States:** IDLE, CALC, FIX, DONE. Each 2-bit FSM state is listed with its next-state transitions below.
- **IDLE:**
  - Accept when `in_valid & mdu_set.mdu_enable`.
  - If `mdu_enable=0`, ignore `in_valid`.
  - On accept, latch the op and signs and zero the 6-bit step counter.
  - Operand extension: `x33 = {signed & x[31], x}`.
- **MULL/MULH (multiply):**
  - `signed_a`/`signed_b` select MULH, MULHSU or MULHU.
  - Registers: `hi` (33 bits) = 0, `lo` = `src2_33`, `mcand` = `src1_33`, `neg_mcand = ~mcand + 1`. A local 33-bit incrementer is allowed for the negation.
  - CALC runs for 33 steps, i = 0..32, with `alu_req.a = hi`.
  - For i < 32, `alu_req.b = lo[0] ? neg_mcand : 0`.
  - For i = 32, `alu_req.b = lo[0] ? mcand : 0`; this subtracts the sign-bit weight.
  - Update each step: `{hi, lo} <= {res_34, lo[32:1]}`, i.e. a 67-bit value shifted right by 1 with `res_34[33]` as the sign.
  - After step 32 go to DONE.
  - MULL returns `lo[31:0]`; MULH returns `{hi, lo}[63:32]`.
- **DIV/REM (divide):**
  - `signed_a` alone selects signedness.
  - On accept, store the magnitudes `|src1|` and `|src2|` (32-bit unsigned), plus `qneg = s1 ^ s2` and `rneg = s1`.
  - `rem` = 0 (33 bits); `quo` = `|src1|`.
  - CALC runs for 32 steps with `alu_req.a = {rem[31:0], quo[31]}` and `alu_req.b = {1'b0, |src2|}`.
  - If `res_34[33]=0`: `rem <= res_34[32:0]`, `quo <= {quo[30:0], 1}`.
  - Otherwise: `rem <= alu_req.a`, `quo <= {quo[30:0], 0}`.
  - After step 31 go to FIX. FIX negates `quo` if `qneg`, negates `rem` if `rneg`, then goes to DONE.
- **Divide by zero** (`src2 == 0` at accept):
  - Skip CALC and FIX and go straight to DONE.
  - DIV returns `32'hFFFF_FFFF`; REM returns `src1`.
- **Signed overflow** (`0x80000000 / -1`): no special path. The magnitude path naturally yields quotient 0x80000000 and remainder 0.
- **DONE:** `out_valid=1` and `result` is stable. Return to IDLE on `out_ready`.
- **Flush:**
  - Takes effect at the next edge from any state; state becomes IDLE and `out_valid` drops.
  - Flush has priority over accept and over `out_ready`.
- **Outside CALC:** `alu_req = '0`.

## Timing
- **Reset values:**
  - state IDLE, so `in_ready=1` and `out_valid=0`.
  - `result = 0`, `alu_req = 0`, counter 0.
- **Latency:** the accept edge is cycle 0; the first CALC cycle is cycle 1.
  - MUL: `out_valid` at cycle 34 (33 CALC cycles).
  - DIV/REM: `out_valid` at cycle 34 (32 CALC + 1 FIX).
  - Divide by zero: `out_valid` at cycle 1.
- **Throughput:** no new op is accepted while `out_valid` is high. The earliest next accept is the cycle after the `out_valid & out_ready` edge.
- **`alu_rsp`:** sampled in the same cycle that `alu_req` is driven. There is no pipeline register between the two.
- **Result stability:** `result` is stable for the whole DONE period, whatever `out_ready` does (backpressure).

## Test plan
- **MULL/MULH:** MULL 7×(−3) → `result 0xFFFFFFEB`. MULH with `src1=src2=0x80000000`, both signed → `0x40000000`. Same operands as MULHU → `0x40000000`. MULHSU with `src1=-1`, `src2=2` → `0xFFFFFFFF`. `out_valid` at cycle 34 in every case.
- **Signed DIV/REM:** DIV −7/2 → `0xFFFFFFFD`. REM −7/2 → `0xFFFFFFFF`. DIVU 0xFFFFFFFE/3 → `0x55555554`. Latency 34.
- **Corner cases:** DIV x/0 → `0xFFFFFFFF` at cycle 1. REM 0x1234/0 → `0x1234`. DIV 0x80000000/−1 → `0x80000000`. REM of the same operands → 0.
- **Backpressure:** hold `out_ready=0` for 10 cycles after `out_valid`. `result` must stay constant, `in_ready` must stay 0, and a concurrent `in_valid` must not be accepted.
- **Flush and reset:** assert `flush` at CALC step 10; the next cycle shows `in_ready=1`, `out_valid=0` and `alu_req=0`. Asserting `reset` mid-DIV gives the same outcome. A subsequent MULL 3×5 returns 15.
- **Enable gating:** `in_valid=1` with `mdu_enable=0` → no state change and `out_valid` never rises.
